// File: rtl/escalonador_rr.sv
// Round-robin process scheduler and OS controller: sequences BIOS boot, context handshakes,
// quantum preemption and process retirement, and maps relative addresses into partitions.
module escalonador_rr #(
   parameter int unsigned NPROC   = 4,
   parameter int unsigned PID_W   = 2,
   parameter int unsigned QUANTUM = 16,
   parameter int unsigned QW      = 8,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned PART    = 50,
   parameter int unsigned BASE_MI = 100,
   parameter int unsigned BASE_MD = 150
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              boot_done,
   input  logic              halt,
   input  logic              preemp_mode,
   input  logic              load_valid,
   input  logic [PID_W-1:0]  load_pid,
   input  logic              ctx_ack,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [ADDR_W-1:0] dado_in,
   output logic              Sel_BIOS,
   output logic [PID_W-1:0]  id_proc,
   output logic [PID_W-1:0]  id_proc_atual,
   output logic              Set_ctx,
   output logic              Set_pid_0,
   output logic              quantum_over,
   output logic              all_done,
   output logic [ADDR_W-1:0] ender_mi,
   output logic [ADDR_W-1:0] ender_md,
   output logic              addr_fault
);

   typedef enum logic [2:0] {
      StBoot, StSelect, StRestore, StRun, StSave, StIdle
   } state_e;

   localparam logic [PID_W-1:0] LastPid = PID_W'(NPROC - 1);
   localparam logic [QW-1:0]    QLast   = QW'(QUANTUM - 1);

   state_e            state_q, state_d;
   logic [NPROC-1:0]  alive_q, alive_d;
   logic [QW-1:0]     counter_q, counter_d;
   logic [PID_W-1:0]  id_proc_q, id_proc_d;
   logic [PID_W-1:0]  atual_q, atual_d;
   logic              sel_bios_q, sel_bios_d;
   logic              set_ctx_q, set_ctx_d;
   logic              set_pid0_q, set_pid0_d;
   logic              qover_q, qover_d;
   logic              all_done_q, all_done_d;

   logic              sel_found;
   logic [PID_W-1:0]  sel_pid;
   logic [PID_W-1:0]  cand;
   logic [31:0]       part_base;

   // Round-robin search starting after the current owner, visiting the owner itself last.
   always_comb begin
      sel_found = 1'b0;
      sel_pid   = '0;
      cand      = atual_q;
      for (int i = 0; i < int'(NPROC) - 1; i++) begin
         cand = (cand >= LastPid) ? PID_W'(1) : cand + PID_W'(1);
         if (!sel_found && alive_q[cand]) begin
            sel_found = 1'b1;
            sel_pid   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      alive_d   = alive_q;
      counter_d = counter_q;
      atual_d   = atual_q;
      qover_d   = 1'b0;
      case (state_q)
         StBoot: begin
            if (boot_done) state_d = StSelect;
         end
         StSelect: begin
            if (sel_found) begin
               state_d = StRestore;
               atual_d = sel_pid;
            end else begin
               state_d = StIdle;
            end
         end
         StRestore: begin
            if (ctx_ack) begin
               state_d   = StRun;
               counter_d = '0;
            end
         end
         StRun: begin
            if (en && counter_q != QLast) counter_d = counter_q + QW'(1);
            if (halt) begin
               alive_d[id_proc_q] = 1'b0;
               state_d            = StSelect;
            end else if (preemp_mode && en && counter_q == QLast) begin
               qover_d = 1'b1;
               state_d = StSave;
            end
         end
         StSave: begin
            if (ctx_ack) state_d = StSelect;
         end
         StIdle: begin
            if (|alive_q[NPROC-1:1]) state_d = StSelect;
         end
         default: state_d = StBoot;
      endcase
      // Applied after the halt clear so a same-cycle load keeps the slot resident.
      if (load_valid && load_pid != '0 && 32'(load_pid) < NPROC) alive_d[load_pid] = 1'b1;
      alive_d[0] = 1'b0;
   end

   always_comb begin
      sel_bios_d = (state_d == StBoot);
      set_ctx_d  = (state_d == StRestore);
      set_pid0_d = (state_d == StSave);
      all_done_d = (state_d == StIdle);
      id_proc_d  = (state_d == StRun) ? atual_d : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StBoot;
         alive_q    <= '0;
         counter_q  <= '0;
         id_proc_q  <= '0;
         atual_q    <= '0;
         sel_bios_q <= 1'b1;
         set_ctx_q  <= 1'b0;
         set_pid0_q <= 1'b0;
         qover_q    <= 1'b0;
         all_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alive_q    <= alive_d;
         counter_q  <= counter_d;
         id_proc_q  <= id_proc_d;
         atual_q    <= atual_d;
         sel_bios_q <= sel_bios_d;
         set_ctx_q  <= set_ctx_d;
         set_pid0_q <= set_pid0_d;
         qover_q    <= qover_d;
         all_done_q <= all_done_d;
      end
   end

   // Partition k starts (k-1)*PART above the partition-1 base; pid 0 is unmapped.
   always_comb begin
      part_base = (32'(id_proc_q) - 32'd1) * PART;
      if (id_proc_q == '0) begin
         ender_mi = pc_in;
         ender_md = dado_in;
      end else begin
         ender_mi = ADDR_W'(BASE_MI + part_base + 32'(pc_in));
         ender_md = ADDR_W'(BASE_MD + part_base + 32'(dado_in));
      end
   end

   assign addr_fault    = (id_proc_q != '0) && ((32'(pc_in) >= PART) || (32'(dado_in) >= PART));
   assign Sel_BIOS      = sel_bios_q;
   assign id_proc       = id_proc_q;
   assign id_proc_atual = atual_q;
   assign Set_ctx       = set_ctx_q;
   assign Set_pid_0     = set_pid0_q;
   assign quantum_over  = qover_q;
   assign all_done      = all_done_q;

endmodule
